// File: rtl/apx_add_pkg.sv
// Shared widths and mode encodings for the approximate-adder responder.
package apx_add_pkg;
   localparam int WIDTH_DEF  = 32;
   localparam int TRUNC      = 0;
   localparam int RND        = 1;
   localparam int PAIR_CNT_W = 32;
   localparam int MISM_CNT_W = 16;
endpackage

// File: rtl/apx_add_core.sv
// Combinational exact and approximate adders; the low NAB bits are truncated or bit-rounded.
module apx_add_core
   import apx_add_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int NAB    = 0,
   parameter int BT_RND = TRUNC
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] c_apx,
   output logic [WIDTH-1:0] c_acc
);
   localparam logic [WIDTH-1:0] LOW_MASK = (WIDTH'(1) << NAB) - WIDTH'(1);

   logic [WIDTH-1:0] a_t, b_t, a_m, b_m;

   assign c_acc = a + b;
   assign a_t   = a & ~LOW_MASK;
   assign b_t   = b & ~LOW_MASK;

   generate
      if (NAB > 0 && BT_RND == RND) begin : g_rnd
         // the dropped MSB carries into the first kept bit; may wrap to zero
         assign a_m = a_t + (WIDTH'(a[NAB-1]) << NAB);
         assign b_m = b_t + (WIDTH'(b[NAB-1]) << NAB);
      end else begin : g_trunc
         assign a_m = a_t;
         assign b_m = b_t;
      end
   endgenerate

   assign c_apx = a_m + b_m;
endmodule

// File: rtl/apx_add_responder.sv
// Two-stage valid/ready pipeline around apx_add_core with error statistics.
module apx_add_responder
   import apx_add_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int NAB    = 0,
   parameter int BT_RND = TRUNC
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_a,
   input  logic [WIDTH-1:0]      in_b,
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic [WIDTH-1:0]      out_c_apx,
   output logic [WIDTH-1:0]      out_c_acc,
   output logic [WIDTH-1:0]      out_err,
   input  logic                  clear_stats,
   output logic [PAIR_CNT_W-1:0] pair_cnt,
   output logic [MISM_CNT_W-1:0] mism_cnt,
   output logic [WIDTH-1:0]      max_abs_err
);
   logic             rdy_en, s1_valid, s2_free, out_fire;
   logic [WIDTH-1:0] s1_a, s1_b, c_apx, c_acc, err_abs;

   apx_add_core #(.WIDTH(WIDTH), .NAB(NAB), .BT_RND(BT_RND)) u_core (
      .a     (s1_a),
      .b     (s1_b),
      .c_apx (c_apx),
      .c_acc (c_acc)
   );

   assign s2_free  = !out_valid || out_ready;
   // rdy_en keeps in_ready low during reset and until the first edge after it
   assign in_ready = rdy_en && (!s1_valid || s2_free);
   assign out_fire = out_valid && out_ready;
   assign err_abs  = out_err[WIDTH-1] ? -out_err : out_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdy_en   <= 1'b0;
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
      end else begin
         rdy_en <= 1'b1;
         if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_a <= in_a;
               s1_b <= in_b;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_c_apx <= '0;
         out_c_acc <= '0;
         out_err   <= '0;
      end else if (s2_free) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_c_apx <= c_apx;
            out_c_acc <= c_acc;
            out_err   <= c_apx - c_acc;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pair_cnt    <= '0;
         mism_cnt    <= '0;
         max_abs_err <= '0;
      end else if (clear_stats) begin
         pair_cnt    <= '0;
         mism_cnt    <= '0;
         max_abs_err <= '0;
      end else if (out_fire) begin
         pair_cnt <= pair_cnt + PAIR_CNT_W'(1);
         if (out_err != '0 && mism_cnt != '1)
            mism_cnt <= mism_cnt + MISM_CNT_W'(1);
         if (err_abs > max_abs_err)
            max_abs_err <= err_abs;
      end
   end
endmodule

// File: tb/tb_apx_add_responder.sv
// Four responder variants (NAB 4/0 x trunc/round) driven in lockstep and checked against a queue model.
`timescale 1ns/1ps
module tb_apx_add_responder;
   localparam int W  = 32;
   localparam int ND = 4;

   logic         clk = 1'b0, rst = 1'b1;
   logic         in_valid = 1'b0, out_ready = 1'b0, clear_stats = 1'b0;
   logic [W-1:0] in_a = '0, in_b = '0;
   logic         in_ready [ND];
   logic         out_valid [ND];
   logic [W-1:0] c_apx [ND], c_acc [ND], err [ND], max_abs [ND];
   logic [31:0]  pair_cnt [ND];
   logic [15:0]  mism_cnt [ND];

   int n_checks = 0, n_fail = 0, n_acc = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < ND; g++) begin : g_dut
      apx_add_responder #(.WIDTH(W), .NAB(g < 2 ? 4 : 0), .BT_RND(g % 2)) dut (
         .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[g]),
         .in_a(in_a), .in_b(in_b), .out_ready(out_ready), .out_valid(out_valid[g]),
         .out_c_apx(c_apx[g]), .out_c_acc(c_acc[g]), .out_err(err[g]),
         .clear_stats(clear_stats), .pair_cnt(pair_cnt[g]), .mism_cnt(mism_cnt[g]),
         .max_abs_err(max_abs[g])
      );
   end

   function automatic void chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   // ---------------- model ----------------
   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      int           t;
   } item_t;

   item_t        q[$];
   int           cyc = 0;
   bit           alive = 0;
   logic [31:0]  m_pair [ND];
   logic [15:0]  m_mism [ND];
   logic [W-1:0] m_max  [ND];

   function automatic logic [W-1:0] apx_op(logic [W-1:0] x, int g);
      int           nab;
      logic [W-1:0] step, t;
      nab  = (g < 2) ? 4 : 0;
      step = 32'(1) << nab;
      t    = x - (x % step);
      if (g % 2 == 1 && nab > 0)
         if ((x / (step / 2)) % 2 == 1) t = t + step;
      return t;
   endfunction

   function automatic logic [W-1:0] m_apx(logic [W-1:0] a, logic [W-1:0] b, int g);
      return apx_op(a, g) + apx_op(b, g);
   endfunction

   function automatic bit exp_ov();
      return !rst && q.size() > 0 && cyc > q[0].t;
   endfunction

   function automatic bit exp_ir();
      return !rst && alive && (q.size() < 2 || out_ready);
   endfunction

   initial begin
      foreach (m_pair[g]) begin m_pair[g] = 0; m_mism[g] = 0; m_max[g] = 0; end
      forever begin
         bit ov, ir;
         @(posedge clk);
         if (rst) begin
            q.delete();
            alive = 0;
            foreach (m_pair[g]) begin m_pair[g] = 0; m_mism[g] = 0; m_max[g] = 0; end
         end else begin
            ov = exp_ov();
            ir = exp_ir();
            cyc++;
            if (ov && out_ready) begin
               for (int g = 0; g < ND; g++) begin
                  logic [W-1:0] e, ab;
                  e  = m_apx(q[0].a, q[0].b, g) - (q[0].a + q[0].b);
                  ab = e[W-1] ? (0 - e) : e;
                  m_pair[g]++;
                  if (e != 0 && m_mism[g] != 16'hFFFF) m_mism[g]++;
                  if (ab > m_max[g]) m_max[g] = ab;
               end
               void'(q.pop_front());
            end
            if (clear_stats)
               foreach (m_pair[g]) begin m_pair[g] = 0; m_mism[g] = 0; m_max[g] = 0; end
            if (in_valid && ir) q.push_back('{in_a, in_b, cyc});
            alive = 1;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge clk);
         for (int g = 0; g < ND; g++) begin
            chk($sformatf("in_ready[%0d]", g), W'(in_ready[g]), W'(exp_ir()));
            chk($sformatf("out_valid[%0d]", g), W'(out_valid[g]), W'(exp_ov()));
            if (exp_ov()) begin
               chk($sformatf("c_apx[%0d]", g), c_apx[g], m_apx(q[0].a, q[0].b, g));
               chk($sformatf("c_acc[%0d]", g), c_acc[g], q[0].a + q[0].b);
               chk($sformatf("err[%0d]", g), err[g], m_apx(q[0].a, q[0].b, g) - (q[0].a + q[0].b));
            end else if (rst) begin
               chk($sformatf("rst_c_apx[%0d]", g), c_apx[g], '0);
               chk($sformatf("rst_c_acc[%0d]", g), c_acc[g], '0);
               chk($sformatf("rst_err[%0d]", g), err[g], '0);
            end
            chk($sformatf("pair_cnt[%0d]", g), pair_cnt[g], rst ? '0 : m_pair[g]);
            chk($sformatf("mism_cnt[%0d]", g), W'(mism_cnt[g]), rst ? '0 : W'(m_mism[g]));
            chk($sformatf("max_abs_err[%0d]", g), max_abs[g], rst ? '0 : m_max[g]);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
      bit done;
      done     = 0;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         done = in_ready[0];
         tick();
      end
      in_valid = 1'b0;
      if (done) n_acc++;
      chk("send_accepted", W'(done), W'(1));
   endtask

   task automatic wait_out();
      bit seen;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = out_valid[0];
      end
      chk("wait_out_valid", W'(seen), W'(1));
   endtask

   initial begin
      // reset state and in_ready rise
      @(negedge clk);
      chk("lit_rst_in_ready", W'(in_ready[0]), 0);
      chk("lit_rst_out_valid", W'(out_valid[0]), 0);
      tick(); tick();
      rst = 1'b0;
      @(negedge clk);
      chk("lit_in_ready_pre_edge", W'(in_ready[0]), 0);
      tick();
      @(negedge clk);
      chk("lit_in_ready_rise", W'(in_ready[0]), 1);
      tick();
      out_ready = 1'b1;

      // truncation vs rounding on 0x1F + 0x11
      send(32'h1F, 32'h11);
      wait_out();
      chk("lit_v1_acc0", c_acc[0], 32'h30);
      chk("lit_v1_apx0", c_apx[0], 32'h20);
      chk("lit_v1_err0", err[0], 32'hFFFF_FFF0);
      chk("lit_v1_apx1", c_apx[1], 32'h30);
      chk("lit_v1_err1", err[1], 32'h0);
      @(negedge clk);
      chk("lit_v1_mism0", W'(mism_cnt[0]), 1);
      chk("lit_v1_max0", max_abs[0], 32'h10);
      chk("lit_v1_mism1", W'(mism_cnt[1]), 0);
      tick();

      // rounding wraps a_r to zero
      send(32'hFFFF_FFF8, 32'h0);
      wait_out();
      chk("lit_v2_apx1", c_apx[1], 32'h0);
      chk("lit_v2_acc1", c_acc[1], 32'hFFFF_FFF8);
      chk("lit_v2_err1", err[1], 32'h8);
      @(negedge clk);
      chk("lit_v2_max1", max_abs[1], 32'h8);
      chk("lit_v2_max0", max_abs[0], 32'h10);
      tick();

      // NAB=0: exact in both modes, including wrap
      send(32'hFFFF_FFFF, 32'h1);
      wait_out();
      chk("lit_v3_apx2", c_apx[2], 32'h0);
      chk("lit_v3_acc3", c_acc[3], 32'h0);
      chk("lit_v3_err3", err[3], 32'h0);
      @(negedge clk);
      chk("lit_v3_mism2", W'(mism_cnt[2]), 0);
      chk("lit_v3_mism3", W'(mism_cnt[3]), 0);
      tick();

      // backpressure: 5 pairs, out_ready low for 6 cycles
      clear_stats = 1'b1;
      out_ready   = 1'b0;
      tick();
      clear_stats = 1'b0;
      n_acc       = 0;
      fork
         begin
            for (int i = 0; i < 5; i++) send(W'(i * 16 + 3), W'(i));
         end
         begin
            for (int i = 0; i < 6; i++) begin
               tick();
               if (i == 4) begin
                  @(negedge clk);
                  chk("lit_bp_in_ready", W'(in_ready[0]), 0);
                  chk("lit_bp_accepts", W'(n_acc), 2);
                  chk("lit_bp_hold_acc", c_acc[0], 32'h3);
               end
            end
            out_ready = 1'b1;
         end
      join
      for (int i = 0; i < 30 && pair_cnt[0] != 5; i++) tick();
      @(negedge clk);
      chk("lit_bp_pair_cnt", pair_cnt[0], 5);
      tick();

      // clear coincident with an output transfer
      send(32'h100, 32'h200);
      wait_out();
      clear_stats = 1'b1;
      tick();
      clear_stats = 1'b0;
      @(negedge clk);
      chk("lit_clear_pair_cnt", pair_cnt[0], 0);
      tick();

      // reset with 2 pairs in flight
      out_ready = 1'b0;
      send(32'h55, 32'h66);
      send(32'h77, 32'h88);
      rst = 1'b1;
      @(negedge clk);
      chk("lit_mid_rst_out_valid", W'(out_valid[0]), 0);
      chk("lit_mid_rst_c_acc", c_acc[0], 0);
      chk("lit_mid_rst_in_ready", W'(in_ready[0]), 0);
      tick(); tick();
      rst       = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         @(negedge clk);
         chk("lit_no_delivery", W'(out_valid[0]), 0);
      end
      chk("lit_no_delivery_cnt", pair_cnt[0], 0);
      tick();

      // random traffic with random backpressure
      for (int i = 0; i < 80; i++) begin
         in_valid    = 1'($urandom_range(0, 1));
         in_a        = $urandom;
         in_b        = (i % 3 == 0) ? W'($urandom_range(0, 255)) : $urandom;
         out_ready   = ($urandom_range(0, 3) != 0);
         clear_stats = ($urandom_range(0, 19) == 0);
         tick();
      end
      in_valid    = 1'b0;
      clear_stats = 1'b0;
      out_ready   = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      @(negedge clk);
      chk("drained", W'(q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
